// File: rtl/glyph_feature_extractor.sv
// glyph_feature_extractor: counts strokes (edges) and diagonal steps (curves) in a row-serial binary glyph
module glyph_feature_extractor #(
  parameter int WIDTH   = 5,
  parameter int HEIGHT  = 7,
  parameter int RUN_MIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             abort,
  output logic [2:0]       edges,
  output logic [3:0]       curves,
  output logic             feat_valid,
  input  logic             feat_ready
);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int CW = $clog2(RUN_MIN + 1);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] run_cnt [WIDTH];
  logic [CW-1:0] run_n [WIDTH];
  logic [IW-1:0] prev_l, prev_r;
  logic prev_stroke, prev_ne, hstroke, nonempty, accept, clear;
  logic [2:0] edges_n;
  logic [3:0] curves_n;
  int run, vsum, l, r, dl, dr, tot_e, tot_c;
  assign pix_ready = state == ACCUM;
  assign feat_valid = state == DONE;
  assign accept = pix_valid & pix_ready & ~abort;
  assign clear = pix_ready ? abort : feat_ready;
  assign nonempty = |pix_data;
  always_comb begin
    state_n = pix_ready ? ((accept && row_cnt == RW'(HEIGHT - 1)) ? DONE : ACCUM)
                        : (feat_ready ? ACCUM : DONE);
  end
  // Row features: horizontal run, per-column vertical runs, leftmost/rightmost set pixel
  always_comb begin
    hstroke = 1'b0;
    run = 0;
    vsum = 0;
    l = 0;
    r = 0;
    for (int i = 0; i < WIDTH; i++) begin
      run = pix_data[i] ? run + 1 : 0;
      hstroke = hstroke | (run >= RUN_MIN);
      run_n[i] = !pix_data[i] ? '0 : (run_cnt[i] == CW'(RUN_MIN)) ? run_cnt[i] : run_cnt[i] + CW'(1);
      vsum = vsum + ((pix_data[i] && run_cnt[i] == CW'(RUN_MIN - 1)) ? 1 : 0);
    end
    for (int i = WIDTH - 1; i >= 0; i--) if (pix_data[i]) l = i;
    for (int i = 0; i < WIDTH; i++) if (pix_data[i]) r = i;
    dl = l - int'(prev_l);
    dr = r - int'(prev_r);
    tot_e = int'(edges) + vsum + ((hstroke && !prev_stroke) ? 1 : 0);
    tot_c = int'(curves) + ((nonempty && prev_ne)
            ? ((dl == 1 || dl == -1) ? 1 : 0) + ((dr == 1 || dr == -1) ? 1 : 0) : 0);
    edges_n = tot_e > 7 ? 3'd7 : 3'(tot_e);
    curves_n = tot_c > 15 ? 4'd15 : 4'(tot_c);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      row_cnt <= '0;
      run_cnt <= '{default: '0};
      edges <= '0;
      curves <= '0;
      prev_stroke <= 1'b0;
      prev_ne <= 1'b0;
      prev_l <= '0;
      prev_r <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        row_cnt <= '0;
        run_cnt <= '{default: '0};
        edges <= '0;
        curves <= '0;
        prev_stroke <= 1'b0;
        prev_ne <= 1'b0;
        prev_l <= '0;
        prev_r <= '0;
      end else if (accept) begin
        row_cnt <= row_cnt + RW'(1);
        run_cnt <= run_n;
        edges <= edges_n;
        curves <= curves_n;
        prev_stroke <= hstroke;
        prev_ne <= nonempty;
        prev_l <= IW'(l);
        prev_r <= IW'(r);
      end
    end
  end
endmodule

// File: tb/tb_glyph_feature_extractor.sv
// tb_glyph_feature_extractor: scoreboard bench for the glyph feature extractor
module tb_glyph_feature_extractor;
  typedef logic [4:0] frame_t [7];
  typedef struct {int e; int c;} res_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] pix_data = '0;
  logic pix_valid = 1'b0, abort = 1'b0, feat_ready = 1'b0;
  logic pix_ready, feat_valid;
  logic [2:0] edges;
  logic [3:0] curves;
  logic [7:0] data8 = '0;
  logic v8 = 1'b0, fr8 = 1'b0;
  logic r8, fv8;
  logic [2:0] e8;
  logic [3:0] c8;
  res_t sb [$];
  int checks = 0, failures = 0;
  frame_t g;

  glyph_feature_extractor dut (.clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .abort(abort), .edges(edges), .curves(curves),
    .feat_valid(feat_valid), .feat_ready(feat_ready));
  glyph_feature_extractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .pix_data(data8), .pix_valid(v8),
    .pix_ready(r8), .abort(1'b0), .edges(e8), .curves(c8), .feat_valid(fv8), .feat_ready(fr8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send_row(input logic [4:0] row);
    pix_data = row;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t rows, input int e, input int c);
    sb.push_back('{e, c});
    for (int i = 0; i < 7; i++) begin
      if (i == 6) chk("fv_before_last", feat_valid, 0);
      send_row(rows[i]);
    end
    chk("fv_after_last", feat_valid, 1);
  endtask

  task automatic take_result();
    res_t exp;
    int n = 0;
    while (!feat_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fv_timeout", feat_valid, 1);
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("edges", edges, exp.e);
      chk("curves", curves, exp.c);
    end
    feat_ready = 1'b1;
    @(posedge clk);
    #1;
    feat_ready = 1'b0;
    chk("take_fv", feat_valid, 0);
    chk("take_pr", pix_ready, 1);
    chk("take_edges", edges, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_edges", edges, 0);
    chk("rst_curves", curves, 0);
    chk("rst_fv", feat_valid, 0);
    chk("rst_pr", pix_ready, 1);
    // "1" glyph then backpressure
    g = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
    send_frame(g, 1, 0);
    pix_valid = 1'b1;
    pix_data = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_pr", pix_ready, 0);
      chk("bp_fv", feat_valid, 1);
      chk("bp_edges", edges, 1);
      chk("bp_curves", curves, 0);
    end
    pix_valid = 1'b0;
    take_result();
    // "7" glyph
    g = '{5'b11111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
    send_frame(g, 2, 0);
    take_result();
    // diagonal
    g = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000, 5'b10000};
    send_frame(g, 1, 8);
    take_result();
    // empty rows break the curve chain
    g = '{5'b00001, 5'b00000, 5'b00010, 5'b00100, 5'b00000, 5'b01000, 5'b10000};
    send_frame(g, 0, 4);
    take_result();
    // only stroke starts count for horizontal strokes
    g = '{5'b00111, 5'b00111, 5'b00000, 5'b11100, 5'b00000, 5'b10101, 5'b00000};
    send_frame(g, 2, 0);
    take_result();
    // abort drops the partial frame and the row presented with it
    for (int i = 0; i < 3; i++) send_row(5'b11111);
    chk("pre_abort_edges", edges, 6);
    abort = 1'b1;
    send_row(5'b11111);
    abort = 1'b0;
    chk("abort_edges", edges, 0);
    chk("abort_pr", pix_ready, 1);
    g = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
    send_frame(g, 1, 0);
    take_result();
    // asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) send_row(5'b01010);
    chk("pre_rst_edges", edges, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_edges", edges, 0);
    chk("arst_curves", curves, 0);
    chk("arst_fv", feat_valid, 0);
    chk("arst_pr", pix_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(g, 1, 0);
    take_result();
    // WIDTH=8: nine increments saturate edges at 7
    v8 = 1'b1;
    data8 = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
    end
    v8 = 1'b0;
    chk("w8_fv", fv8, 1);
    chk("w8_pr", r8, 0);
    chk("w8_edges", e8, 7);
    chk("w8_curves", c8, 0);
    fr8 = 1'b1;
    @(posedge clk);
    #1;
    fr8 = 1'b0;
    chk("w8_take_fv", fv8, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
